// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped byte cache.
package cache_pkg;
    localparam int ADDR_W = system_widths_pkg::ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        FILL_REQ,
        FILL_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } cache_state_e;

    function automatic int calc_off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int num_lines, input int line_bytes);
        return ADDR_W - $clog2(num_lines) - $clog2(line_bytes);
    endfunction
endpackage

// File: rtl/system_widths_pkg.sv
// System-wide bus widths shared by the CPU, the caches and the memory model.
package system_widths_pkg;
    localparam int ADDR_W = 11;
endpackage

// File: rtl/cache_mem_if.sv
// Single-outstanding byte memory bus between the cache (master) and the memory model.
interface cache_mem_if;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [cache_pkg::ADDR_W-1:0] req_addr;
    logic [7:0]                 req_write;
    logic                       resp_valid;
    logic [7:0]                 resp_data;

    modport master (
        output req_valid, req_we, req_addr, req_write,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_write,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/data storage for the byte cache: combinational lookup, one byte write port,
// per-line valid set/clear. Only the valid bits are reset; tags and data are left as-is.
module cache_line_store #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BYTES = 4,
    parameter int IDX_W      = 4,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [IDX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [OFF_W-1:0] lookup_off,
    output logic             lookup_hit,
    output logic [7:0]       lookup_byte,
    input  logic [IDX_W-1:0] line_index,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [7:0]       wr_data,
    input  logic             valid_set,
    input  logic             valid_clr,
    input  logic [TAG_W-1:0] set_tag
);
    logic [7:0]       data_mem [NUM_LINES*LINE_BYTES];
    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    logic             valid_reg [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    valid_reg[gi] <= 1'b0;
                end else if (line_index == IDX_W'(gi)) begin
                    if (valid_clr)
                        valid_reg[gi] <= 1'b0;
                    else if (valid_set)
                        valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[{line_index, wr_off}] <= wr_data;
        if (valid_set)
            tag_mem[line_index] <= set_tag;
    end

    assign lookup_hit  = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
    assign lookup_byte = data_mem[{lookup_index, lookup_off}];
endmodule

// File: rtl/dm_byte_cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache with sequential line fills.
// Optional load hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_byte_cache
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BYTES = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [7:0]        cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [7:0]        cpu_resp_rdata,
    cache_mem_if.master       mem_if
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);
    localparam int OFF_W = calc_off_w(LINE_BYTES);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(NUM_LINES, LINE_BYTES);

    cache_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic [7:0]        rdata_reg, rdata_next;
    logic [OFF_W-1:0]  beat_reg, beat_next;

    logic [IDX_W-1:0]  cpu_idx, idx_reg, line_idx;
    logic [TAG_W-1:0]  cpu_tag, tag_reg;
    logic [OFF_W-1:0]  off_reg, wr_off;
    logic              lu_hit, wr_en, valid_set, valid_clr;
    logic [7:0]        lu_byte, wr_data;

    assign cpu_idx = cpu_req_addr[OFF_W+IDX_W-1:OFF_W];
    assign cpu_tag = cpu_req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign off_reg = addr_reg[OFF_W-1:0];
    assign idx_reg = addr_reg[OFF_W+IDX_W-1:OFF_W];
    assign tag_reg = addr_reg[ADDR_W-1:OFF_W+IDX_W];

    cache_line_store #(
        .NUM_LINES  (NUM_LINES),
        .LINE_BYTES (LINE_BYTES),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk          (clk),
        .resetN       (resetN),
        .lookup_index (cpu_idx),
        .lookup_tag   (cpu_tag),
        .lookup_off   (cpu_req_addr[OFF_W-1:0]),
        .lookup_hit   (lu_hit),
        .lookup_byte  (lu_byte),
        .line_index   (line_idx),
        .wr_en        (wr_en),
        .wr_off       (wr_off),
        .wr_data      (wr_data),
        .valid_set    (valid_set),
        .valid_clr    (valid_clr),
        .set_tag      (tag_reg)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        rdata_next        = rdata_reg;
        beat_next         = beat_reg;
        line_idx          = idx_reg;
        wr_en             = 1'b0;
        wr_off            = beat_reg;
        wr_data           = mem_if.resp_data;
        valid_set         = 1'b0;
        valid_clr         = 1'b0;
        cpu_req_ready     = 1'b0;
        cpu_resp_valid    = 1'b0;
        cpu_resp_rdata    = 8'h00;
        mem_if.req_valid  = 1'b0;
        mem_if.req_we     = 1'b0;
        mem_if.req_addr   = '0;
        mem_if.req_write  = 8'h00;

        case (state_reg)
            IDLE: begin
                cpu_req_ready = 1'b1;
                line_idx      = cpu_idx;
                if (cpu_req_valid) begin
                    addr_next  = cpu_req_addr;
                    wdata_next = cpu_req_wdata;
                    if (cpu_req_we) begin
                        rdata_next = 8'h00;
                        state_next = WR_REQ;
                        // Store hit updates the line now; the memory write follows.
                        wr_en      = lu_hit;
                        wr_off     = cpu_req_addr[OFF_W-1:0];
                        wr_data    = cpu_req_wdata;
                    end else if (lu_hit) begin
                        rdata_next = lu_byte;
                        state_next = RESP;
                    end else begin
                        beat_next  = '0;
                        valid_clr  = 1'b1;
                        state_next = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                mem_if.req_valid = 1'b1;
                mem_if.req_addr  = {addr_reg[ADDR_W-1:OFF_W], beat_reg};
                if (mem_if.req_ready)
                    state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_if.resp_valid) begin
                    wr_en = 1'b1;
                    if (beat_reg == off_reg)
                        rdata_next = mem_if.resp_data;
                    if (&beat_reg) begin
                        valid_set  = 1'b1;
                        state_next = RESP;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = FILL_REQ;
                    end
                end
            end
            WR_REQ: begin
                mem_if.req_valid = 1'b1;
                mem_if.req_we    = 1'b1;
                mem_if.req_addr  = addr_reg;
                mem_if.req_write = wdata_reg;
                if (mem_if.req_ready)
                    state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_if.resp_valid)
                    state_next = RESP;
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = rdata_reg;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_reg, miss_count_reg;
    logic        load_accept;

    assign load_accept = (state_reg == IDLE) && cpu_req_valid && !cpu_req_we;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_count_reg  <= 16'h0000;
            miss_count_reg <= 16'h0000;
        end else if (load_accept) begin
            if (lu_hit && hit_count_reg != 16'hFFFF)
                hit_count_reg <= hit_count_reg + 16'h0001;
            else if (!lu_hit && miss_count_reg != 16'hFFFF)
                miss_count_reg <= miss_count_reg + 16'h0001;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif
endmodule
